// File: rtl/inst_rom.sv
// Fetch-side instruction memory: registered 1-cycle read of the word addressed by the PC,
// with a write-only program port, error flagging for bad fetches and an accepted-fetch counter.
module inst_rom #(
  parameter int unsigned AW        = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [31:0]   addr,
  input  logic          stall,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic          addr_err,
  output logic [31:0]   fetch_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] mem [0:(1<<AW)-1];

  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic [31:0]   rd_word;

  // Program writes land via NBA, so a same-edge fetch still captures the old word.
  always_ff @(posedge clk) begin
    if (rst && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    word_idx     = addr[AW+1:2];
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr[31:AW+2] != '0);
    rd_word      = mem[word_idx];
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    addr_err_d  = addr_err_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!stall) begin
      if (ce) begin
        state_d     = S_VALID;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (misaligned || out_of_range) begin
          inst_d     = '0;
          addr_err_d = 1'b1;
        end else begin
          inst_d     = rd_word;
          addr_err_d = 1'b0;
        end
      end else begin
        state_d    = S_IDLE;
        inst_d     = '0;
        addr_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      addr_err_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      addr_err_q  <= addr_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = (state_q == S_VALID);
  assign addr_err   = addr_err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule
